// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one request per cycle, answers in order
// after a fixed number of wait cycles, with a one-entry pending buffer behind the active request.
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_fence,
    input  logic        mem_spec,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam state_t ENTRY_STATE = (WAIT > 0) ? ST_WAIT : ST_RESP;

    typedef struct packed {
        logic        fence;
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic out_of_range(input logic [29:0] waddr);
        return (waddr >> AW) != 30'd0;
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    req_t        act_r, act_s;
    req_t        pend_r, pend_s;
    logic        pend_valid_r, pend_valid_s;
    logic        overflow_r, overflow_s;
    req_t        new_req_s;
    logic        commit_s;
    logic        resp_s;
    logic        resp_error_s;
    logic [31:0] stored_word_s;
    logic [31:0] fwd_word_s;
    logic [31:0] resp_rdata_s;
    logic        ready_r;
    logic [31:0] rdata_r;
    logic        error_r;
    logic [31:0] mem_r [DEPTH];
    logic        unused_s;

    assign new_req_s = {mem_fence, mem_addr[31:2], mem_wdata, mem_wstrb};
    assign unused_s  = ^{mem_spec, mem_instr, mem_addr[1:0]};

    // Next-state logic: active slot, pending buffer, wait counter and sticky overflow.
    // A request arriving in RESP with the pending buffer empty goes straight into the
    // freed active slot, which is the same as capturing it and promoting it at once.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        act_s        = act_r;
        pend_s       = pend_r;
        pend_valid_s = pend_valid_r;
        overflow_s   = overflow_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_valid) begin
                    act_s   = new_req_s;
                    state_s = ENTRY_STATE;
                    cnt_s   = WAIT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
                if (mem_valid && !pend_valid_r) begin
                    pend_s       = new_req_s;
                    pend_valid_s = 1'b1;
                end else if (mem_valid) begin
                    overflow_s = 1'b1;
                end else begin
                    overflow_s = overflow_r;
                end
            end
            ST_RESP: begin
                if (pend_valid_r) begin
                    act_s   = pend_r;
                    state_s = ENTRY_STATE;
                    cnt_s   = WAIT_LOAD;
                    if (mem_valid) begin
                        pend_s = new_req_s;
                    end else begin
                        pend_valid_s = 1'b0;
                    end
                end else if (mem_valid) begin
                    act_s   = new_req_s;
                    state_s = ENTRY_STATE;
                    cnt_s   = WAIT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Response data for the request entering RESP, forwarding a store committing this edge.
    always_comb begin
        commit_s      = (state_r == ST_RESP) && !act_r.fence && (act_r.wstrb != 4'd0)
                        && !out_of_range(act_r.waddr);
        resp_s        = (state_s == ST_RESP);
        resp_error_s  = !act_s.fence && out_of_range(act_s.waddr);
        stored_word_s = mem_r[act_s.waddr[AW-1:0]];
        if (commit_s && (act_r.waddr == act_s.waddr)) begin
            fwd_word_s = merge_lanes(stored_word_s, act_r.wdata, act_r.wstrb);
        end else begin
            fwd_word_s = stored_word_s;
        end
        if (resp_s && !act_s.fence && (act_s.wstrb == 4'd0) && !resp_error_s) begin
            resp_rdata_s = fwd_word_s;
        end else begin
            resp_rdata_s = 32'd0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            act_r        <= '0;
            pend_r       <= '0;
            pend_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            ready_r      <= 1'b0;
            rdata_r      <= 32'd0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            act_r        <= act_s;
            pend_r       <= pend_s;
            pend_valid_r <= pend_valid_s;
            overflow_r   <= overflow_s;
            ready_r      <= resp_s;
            rdata_r      <= resp_rdata_s;
            error_r      <= resp_s && resp_error_s;
        end
    end

    // Data array: not reset; a store commits at the end of its RESP cycle.
    always_ff @(posedge clock) begin
        if (reset && commit_s) begin
            mem_r[act_r.waddr[AW-1:0]] <= merge_lanes(mem_r[act_r.waddr[AW-1:0]],
                                                      act_r.wdata, act_r.wstrb);
        end
    end

    assign mem_ready = ready_r;
    assign mem_rdata = rdata_r;
    assign mem_error = error_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WAIT=1, WAIT=2, WAIT=0) driven
// by one linear sequence with hand-computed expectations.
module tb_dmem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        side_bit;
    logic        v  [3];
    logic        fe [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic [3:0]  ws [3];
    logic        rdy[3];
    logic        err[3];
    logic        ovf[3];
    logic [31:0] rd [3];
    int          total = 0;
    int          fails = 0;

    dmem_responder #(.DEPTH(1024), .WAIT(1)) u_a (
        .clock(clock), .reset(reset), .mem_valid(v[0]), .mem_fence(fe[0]),
        .mem_spec(side_bit), .mem_instr(side_bit), .mem_addr(ad[0]), .mem_wdata(wd[0]),
        .mem_wstrb(ws[0]), .mem_ready(rdy[0]), .mem_rdata(rd[0]), .mem_error(err[0]),
        .overflow(ovf[0]));

    dmem_responder #(.DEPTH(1024), .WAIT(2)) u_b (
        .clock(clock), .reset(reset), .mem_valid(v[1]), .mem_fence(fe[1]),
        .mem_spec(side_bit), .mem_instr(side_bit), .mem_addr(ad[1]), .mem_wdata(wd[1]),
        .mem_wstrb(ws[1]), .mem_ready(rdy[1]), .mem_rdata(rd[1]), .mem_error(err[1]),
        .overflow(ovf[1]));

    dmem_responder #(.DEPTH(64), .WAIT(0)) u_c (
        .clock(clock), .reset(reset), .mem_valid(v[2]), .mem_fence(fe[2]),
        .mem_spec(side_bit), .mem_instr(side_bit), .mem_addr(ad[2]), .mem_wdata(wd[2]),
        .mem_wstrb(ws[2]), .mem_ready(rdy[2]), .mem_rdata(rd[2]), .mem_error(err[2]),
        .overflow(ovf[2]));

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic chk1(input string tag, input logic o, input logic e);
        total++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic put(input int d, input logic f, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] s);
        v[d]  = 1'b1;
        fe[d] = f;
        ad[d] = a;
        wd[d] = w;
        ws[d] = s;
    endtask

    task automatic clr(input int d);
        v[d]  = 1'b0;
        fe[d] = 1'b0;
        ad[d] = 32'd0;
        wd[d] = 32'd0;
        ws[d] = 4'd0;
    endtask

    // One isolated request: ready must appear exactly lat cycles after the request cycle.
    task automatic xact(input string tag, input int d, input int lat, input logic f,
                        input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                        input logic [31:0] exp_rd, input logic exp_er);
        put(d, f, a, w, s);
        tick();
        clr(d);
        for (int i = 1; i < lat; i++) begin
            chk1({tag, " early"}, rdy[d], 1'b0);
            tick();
        end
        chk1({tag, " ready"}, rdy[d], 1'b1);
        chk({tag, " rdata"}, rd[d], exp_rd);
        chk1({tag, " error"}, err[d], exp_er);
        tick();
        chk1({tag, " pulse"}, rdy[d], 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        side_bit = 1'b0;
        for (int d = 0; d < 3; d++) clr(d);
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            chk1($sformatf("rst ready %0d", d), rdy[d], 1'b0);
            chk($sformatf("rst rdata %0d", d), rd[d], 32'd0);
            chk1($sformatf("rst error %0d", d), err[d], 1'b0);
            chk1($sformatf("rst overflow %0d", d), ovf[d], 1'b0);
        end
        reset    = 1'b1;
        side_bit = 1'b1;
        tick();

        // WAIT=1: full store, loads, partial store, address low bits ignored
        xact("a st10", 0, 2, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
        xact("a ld10", 0, 2, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);
        xact("a st14", 0, 2, 1'b0, 32'h14, 32'h11223344, 4'hF, 32'd0, 1'b0);
        xact("a pst14", 0, 2, 1'b0, 32'h14, 32'h0000AA00, 4'b0010, 32'd0, 1'b0);
        xact("a ld14", 0, 2, 1'b0, 32'h14, 32'd0, 4'h0, 32'h1122AA44, 1'b0);
        xact("a ld17", 0, 2, 1'b0, 32'h17, 32'd0, 4'h0, 32'h1122AA44, 1'b0);

        // out of range: error, no write (0x1010 would alias word 4 if truncated)
        xact("a ldoor", 0, 2, 1'b0, 32'h1000, 32'd0, 4'h0, 32'd0, 1'b1);
        xact("a stoor", 0, 2, 1'b0, 32'h1010, 32'h55555555, 4'hF, 32'd0, 1'b1);
        xact("a ld10b", 0, 2, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);
        xact("a fnoor", 0, 2, 1'b1, 32'h2000, 32'd0, 4'h0, 32'd0, 1'b0);

        // store then fence next cycle: fence answers after the store, two cycles later
        put(0, 1'b0, 32'h18, 32'hCAFEF00D, 4'hF);
        tick();
        chk1("a sf early", rdy[0], 1'b0);
        put(0, 1'b1, 32'h18, 32'h12121212, 4'hF);
        tick();
        clr(0);
        chk1("a sf st ready", rdy[0], 1'b1);
        chk("a sf st rdata", rd[0], 32'd0);
        tick();
        chk1("a sf gap", rdy[0], 1'b0);
        tick();
        chk1("a sf fence ready", rdy[0], 1'b1);
        chk("a sf fence rdata", rd[0], 32'd0);
        chk1("a sf fence error", err[0], 1'b0);
        tick();
        chk1("a sf fence pulse", rdy[0], 1'b0);
        xact("a ld18", 0, 2, 1'b0, 32'h18, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0);

        // WAIT=2: three back-to-back requests, third dropped
        xact("b st48", 1, 3, 1'b0, 32'h48, 32'h12345678, 4'hF, 32'd0, 1'b0);
        put(1, 1'b0, 32'h40, 32'h11111111, 4'hF);
        tick();
        chk1("b t1", rdy[1], 1'b0);
        put(1, 1'b0, 32'h44, 32'h22222222, 4'hF);
        tick();
        chk1("b t2", rdy[1], 1'b0);
        chk1("b t2 overflow", ovf[1], 1'b0);
        put(1, 1'b0, 32'h48, 32'h33333333, 4'hF);
        tick();
        clr(1);
        chk1("b t3 ready", rdy[1], 1'b1);
        chk1("b t3 overflow", ovf[1], 1'b1);
        tick();
        chk1("b t4", rdy[1], 1'b0);
        tick();
        chk1("b t5", rdy[1], 1'b0);
        tick();
        chk1("b t6 ready", rdy[1], 1'b1);
        tick();
        chk1("b t7", rdy[1], 1'b0);
        xact("b ld40", 1, 3, 1'b0, 32'h40, 32'd0, 4'h0, 32'h11111111, 1'b0);
        xact("b ld44", 1, 3, 1'b0, 32'h44, 32'd0, 4'h0, 32'h22222222, 1'b0);
        xact("b ld48", 1, 3, 1'b0, 32'h48, 32'd0, 4'h0, 32'h12345678, 1'b0);
        chk1("b overflow sticky", ovf[1], 1'b1);

        // WAIT=0: single-cycle latency, back-to-back store/partial/load on one word
        xact("c st08", 2, 1, 1'b0, 32'h08, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0);
        xact("c ld08", 2, 1, 1'b0, 32'h08, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0);
        put(2, 1'b0, 32'h0C, 32'h01020304, 4'hF);
        tick();
        chk1("c b2b st ready", rdy[2], 1'b1);
        put(2, 1'b0, 32'h0C, 32'hFF000000, 4'b1000);
        tick();
        chk1("c b2b pst ready", rdy[2], 1'b1);
        chk("c b2b pst rdata", rd[2], 32'd0);
        put(2, 1'b0, 32'h0C, 32'd0, 4'h0);
        tick();
        clr(2);
        chk1("c b2b ld ready", rdy[2], 1'b1);
        chk("c b2b ld rdata", rd[2], 32'hFF020304);
        tick();
        chk1("c b2b end", rdy[2], 1'b0);
        xact("c oor", 2, 1, 1'b0, 32'h100, 32'd0, 4'h0, 32'd0, 1'b1);

        // reset during the wait of a store abandons it
        xact("a st20", 0, 2, 1'b0, 32'h20, 32'h0BADC0DE, 4'hF, 32'd0, 1'b0);
        put(0, 1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
        tick();
        clr(0);
        reset = 1'b0;
        tick();
        chk1("a rst no ready 1", rdy[0], 1'b0);
        tick();
        chk1("a rst no ready 2", rdy[0], 1'b0);
        chk1("b rst overflow clr", ovf[1], 1'b0);
        reset = 1'b1;
        tick();
        chk1("a rst no ready 3", rdy[0], 1'b0);
        xact("a ld20", 0, 2, 1'b0, 32'h20, 32'd0, 4'h0, 32'h0BADC0DE, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words in the data array (power of two).
REQ-002 SHALL have parameter WAIT, default 1, number of wait cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clock  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port mem_valid  in  1  request strobe, one cycle per request.
REQ-006 SHALL have port mem_fence  in  1  request is a fence; qualified by mem_valid.
REQ-007 SHALL have port mem_spec  in  1  speculative hint; ignored.
REQ-008 SHALL have port mem_instr  in  1  instruction-fetch hint; ignored.
REQ-009 SHALL have port mem_addr  in  32  byte address.
REQ-010 SHALL have port mem_wdata  in  32  store data, lane-aligned.
REQ-011 SHALL have port mem_wstrb  in  4  byte enables; 4'h0 = load.
REQ-012 SHALL have port mem_ready  out  1  response strobe, one cycle per accepted request.
REQ-013 SHALL have port mem_rdata  out  32  load data, valid with mem_ready.
REQ-014 SHALL have port mem_error  out  1  out-of-range access, valid with mem_ready.
REQ-015 SHALL have port overflow  out  1  sticky: request dropped because pending buffer full.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 IDLE + mem_valid SHALL capture fence/addr/wdata/wstrb into the active slot; next state WAIT if WAIT>0, else RESP.
REQ-018 WAIT SHALL load a 4-bit counter with WAIT-1 on entry, decrement each cycle, and go to RESP the cycle after it reads 0.
REQ-019 RESP SHALL assert mem_ready for exactly one cycle, then go to IDLE, or, if the pending buffer is full, promote it to active and go to WAIT/RESP as in REQ-017.
REQ-020 Total latency SHALL be WAIT+1 cycles from the mem_valid cycle to the mem_ready cycle.
REQ-021 mem_valid in WAIT or RESP SHALL be captured into a one-entry pending buffer if it is empty.
REQ-022 mem_valid while the pending buffer is full SHALL be dropped and set overflow, which stays set until reset.
REQ-023 In RESP with pending full and a simultaneous mem_valid, promotion SHALL occur and the new request SHALL be captured into the freed pending buffer.
REQ-024 Requests SHALL complete in acceptance order; a fence SHALL respond only after all earlier requests have responded.
REQ-025 Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored (alignment is checked upstream).
REQ-026 addr >= DEPTH*4 SHALL give mem_error=1, mem_rdata=0, and no array write.
REQ-027 A store (wstrb != 0) SHALL commit in the RESP cycle: lane i takes wdata[8i+7:8i] when wstrb[i]=1; other lanes are unchanged.
REQ-028 Load mem_rdata SHALL return the full 32-bit word read in the RESP cycle, reflecting all earlier committed stores.
REQ-029 Stores and fences SHALL return mem_rdata=0.
REQ-030 A fence SHALL not access the array, and SHALL return mem_error=0.
REQ-031 Outside RESP, mem_ready=0, mem_error=0 and mem_rdata=0.

Reset
REQ-032 reset=0 at a clock edge SHALL force state=IDLE, counter=0, pending empty, mem_ready=0, mem_rdata=0, mem_error=0, overflow=0.
REQ-033 Reset mid-operation SHALL abandon the active and pending requests with no mem_ready pulse and no array write.
REQ-034 Array contents SHALL not be reset.

Verification
REQ-035 WAIT=1: store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF at cycle t -> mem_ready at t+2; load 0x10 -> mem_rdata 0xDEADBEEF.
REQ-036 Partial store: word holds 0x11223344; store wdata 0x0000AA00, wstrb 4'b0010 -> load returns 0x1122AA44.
REQ-037 WAIT=2, three mem_valid in cycles t, t+1, t+2 -> first two respond at t+3 and t+6 in order, third dropped, overflow=1.
REQ-038 Load addr DEPTH*4 -> mem_error=1 and mem_rdata=0 with mem_ready; the array is unchanged.
REQ-039 Store followed next cycle by a fence -> fence mem_ready only after the store response, mem_rdata=0.
REQ-040 Reset asserted during WAIT of a store to 0x20 -> no mem_ready; a subsequent load of 0x20 returns the prior contents.
